// File: rtl/bus_arbiter_mux_pkg.sv
// Shared types and constants for the bus arbiter/multiplexer and its helpers.
// FSM states and MODE encodings live here so other arbiters can reuse them.
package bus_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/bus_arbiter_mux_rr_pick.sv
// Combinational round-robin finder: first requesting channel after 'last',
// wrapping modulo NCH (not modulo 2^SELW), so non-power-of-two counts work.
module rr_pick #(
    parameter int NCH  = 8,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] last,
    output logic            found,
    output logic [SELW-1:0] index
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int off = NCH; off >= 1; off--) begin
            for (int i = 0; i < NCH; i++) begin
                if (req[i] && (i == ((int'(last) + off) % NCH))) begin
                    found = 1'b1;
                    index = SELW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Parametrised NCH:1 bus multiplexer with fixed/round-robin arbitration,
// per-channel burst lock and a registered valid/ready output stage.
module bus_arbiter_mux
    import bus_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 8,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NCH*WIDTH-1:0] D,
    input  logic [NCH-1:0]       REQ,
    input  logic [NCH-1:0]       LOCK,
    output logic [NCH-1:0]       GNT,
    input  logic                 MODE,
    input  logic [SELW-1:0]      SEL,
    output logic [WIDTH-1:0]     DATABUS,
    output logic                 VALID,
    input  logic                 READY,
    output logic [SELW-1:0]      CHAN
);

    state_t            state_q, state_d;
    logic [SELW-1:0]   last_q, last_d;
    logic [SELW-1:0]   lch_q, lch_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic [SELW-1:0]   chan_q, chan_d;

    logic              rr_found;
    logic [SELW-1:0]   rr_index;
    logic              pick_found;
    logic [SELW-1:0]   pick_idx;
    logic [WIDTH-1:0]  pick_data;
    logic              acc;

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_pick (
        .req   (REQ),
        .last  (last_q),
        .found (rr_found),
        .index (rr_index)
    );

    // A locked burst owns the bus regardless of MODE/SEL until its last beat.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        if (state_q == LOCKED) begin
            pick_idx   = lch_q;
            pick_found = REQ[lch_q];
        end else if (MODE == MODE_RR) begin
            pick_idx   = rr_index;
            pick_found = rr_found;
        end else if (int'(SEL) < NCH) begin
            pick_idx   = SEL;
            pick_found = REQ[SEL];
        end
    end

    assign acc = RST_N && pick_found && (!valid_q || READY);

    always_comb begin
        pick_data = '0;
        GNT       = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pick_idx == SELW'(i)) begin
                pick_data = D[i*WIDTH +: WIDTH];
                GNT[i]    = acc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        lch_d   = lch_q;
        data_d  = data_q;
        valid_d = valid_q;
        chan_d  = chan_q;
        if (acc) begin
            data_d  = pick_data;
            chan_d  = pick_idx;
            valid_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (MODE == MODE_RR) begin
                        last_d = pick_idx;
                    end
                    if (LOCK[pick_idx]) begin
                        state_d = LOCKED;
                        lch_d   = pick_idx;
                    end
                end
                LOCKED: begin
                    if (!LOCK[lch_q]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end
    end

    // Pointer resets to NCH-1 so the very first round-robin search starts at 0.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            last_q  <= SELW'(NCH - 1);
            lch_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lch_q   <= lch_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
        end
    end

    assign DATABUS = data_q;
    assign VALID   = valid_q;
    assign CHAN    = chan_q;

endmodule
